// File: rtl/inst_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : inst_fetch_queue
// Description : Instruction fetch unit. It reads a combinational ROM and
//               buffers {pc, word} pairs in a FIFO. A redirect flushes the
//               FIFO and restarts fetching at a new PC.
//               Optional macro FETCH_STAT_EN adds the stat_empty counter.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 4
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  fetch_en,
   input  logic                  redirect,
   input  logic [ADDR_W-1:0]     redirect_pc,
   output logic [ADDR_W-1:0]     rom_addr,
   input  logic [DATA_W-1:0]     rom_data,
   output logic [DATA_W-1:0]     Instruction,
   output logic [ADDR_W-1:0]     inst_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [$clog2(DEPTH):0] count
`ifdef FETCH_STAT_EN
   ,
   output logic [31:0]           stat_empty
`endif
);

   localparam int                PTR_W    = $clog2(DEPTH);
   localparam int                CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];

   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;

   logic push;
   logic pop;

   assign inst_valid  = (count_q != '0);
   assign pop         = inst_valid & inst_ready;
   // A full queue still accepts a word when the head leaves in the same cycle.
   assign push        = fetch_en & ~redirect & ((count_q != FULL_CNT) | pop);

   assign rom_addr    = fetch_pc_q;
   assign count       = count_q;
   assign Instruction = data_q[head_q];
   assign inst_pc     = pc_q[head_q];

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      fetch_pc_d = fetch_pc_q;
      if (redirect) begin
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         fetch_pc_d = redirect_pc;
      end else begin
         if (push) begin
            tail_d     = tail_q + PTR_W'(1);
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
         end
         if (pop) begin
            head_d = head_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         fetch_pc_q <= RESET_PC;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   // Payload storage carries no reset; the occupancy count alone marks it valid.
   always_ff @(posedge Clock) begin
      if (push) begin
         data_q[tail_q] <= rom_data;
         pc_q[tail_q]   <= fetch_pc_q;
      end
   end

`ifdef FETCH_STAT_EN
   logic [31:0] stat_q;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         stat_q <= '0;
      end else if (!inst_valid && (stat_q != 32'hFFFF_FFFF)) begin
         stat_q <= stat_q + 32'd1;
      end
   end

   assign stat_empty = stat_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_queue
// Description : Directed self-checking bench for inst_fetch_queue. It drives a
//               32-bit instance and an 8-bit address-wrap instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        fetch_en, redirect, inst_ready;
   logic [31:0] redirect_pc;
   logic [31:0] rom_addr, rom_data, Instruction, inst_pc;
   logic        inst_valid;
   logic [2:0]  count;
`ifdef FETCH_STAT_EN
   logic [31:0] stat_empty;
`endif

   logic        fe8, ready8, valid8;
   logic [7:0]  rom_addr8, inst_pc8;
   logic [31:0] rom_data8, instr8;
   logic [2:0]  count8;

   int errors = 0;
   int checks = 0;

   always #5 Clock = ~Clock;

   // The ROM word is the address XOR a marker, so PC and data stay distinguishable.
   assign rom_data  = rom_addr ^ K;
   assign rom_data8 = {24'h0, rom_addr8} ^ K;

   inst_fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dut (
      .Clock(Clock), .Reset(Reset), .fetch_en(fetch_en), .redirect(redirect),
      .redirect_pc(redirect_pc), .rom_addr(rom_addr), .rom_data(rom_data),
      .Instruction(Instruction), .inst_pc(inst_pc), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .count(count)
`ifdef FETCH_STAT_EN
      , .stat_empty(stat_empty)
`endif
   );

   inst_fetch_queue #(.DATA_W(32), .ADDR_W(8), .DEPTH(4), .RESET_PC(8'hFC), .PC_STEP(4)) dut8 (
      .Clock(Clock), .Reset(Reset), .fetch_en(fe8), .redirect(1'b0),
      .redirect_pc(8'h00), .rom_addr(rom_addr8), .rom_data(rom_data8),
      .Instruction(instr8), .inst_pc(inst_pc8), .inst_valid(valid8),
      .inst_ready(ready8), .count(count8)
`ifdef FETCH_STAT_EN
      , .stat_empty()
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   initial begin
      Reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
      redirect_pc = 32'h0; fe8 = 1'b0; ready8 = 1'b0;
      #3;
      chk("rst_count", {29'b0, count}, 32'd0);
      chk("rst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_rom_addr", rom_addr, 32'h0);
      chk("rst_rom_addr8", {24'b0, rom_addr8}, 32'hFC);
      @(negedge Clock);
      @(negedge Clock);
      Reset = 1'b0;

`ifdef FETCH_STAT_EN
      repeat (10) step();
      chk("stat_empty_10", stat_empty, 32'd10);
      chk("stat_count_idle", {29'b0, count}, 32'd0);
`endif

      // Fill with the consumer stalled.
      fetch_en = 1'b1;
      step();
      chk("fill1_count", {29'b0, count}, 32'd1);
      chk("fill1_valid", {31'b0, inst_valid}, 32'd1);
      chk("fill1_pc", inst_pc, 32'h0);
      chk("fill1_instr", Instruction, 32'h0 ^ K);
      chk("fill1_rom_addr", rom_addr, 32'h4);
      repeat (3) step();
      chk("full_count", {29'b0, count}, 32'd4);
      chk("full_rom_addr", rom_addr, 32'h10);
      step();
      chk("full_hold_count", {29'b0, count}, 32'd4);
      chk("full_hold_rom_addr", rom_addr, 32'h10);
      chk("full_hold_pc", inst_pc, 32'h0);

      // Streaming at full occupancy.
      inst_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("stream_pc", inst_pc, 32'(4 * i));
         chk("stream_instr", Instruction, 32'(4 * i) ^ K);
         chk("stream_count", {29'b0, count}, 32'd4);
      end
      chk("stream_rom_addr", rom_addr, 32'h20);

      // Fetch frozen, pop continues.
      fetch_en = 1'b0;
      step();
      chk("freeze_count", {29'b0, count}, 32'd3);
      chk("freeze_pc", inst_pc, 32'h14);
      chk("freeze_rom_addr", rom_addr, 32'h20);

      // Redirect overrides both push and pop.
      redirect = 1'b1; redirect_pc = 32'h400; fetch_en = 1'b1; inst_ready = 1'b1;
      step();
      chk("redir_count", {29'b0, count}, 32'd0);
      chk("redir_valid", {31'b0, inst_valid}, 32'd0);
      chk("redir_rom_addr", rom_addr, 32'h400);
      redirect = 1'b0; inst_ready = 1'b0;
      step();
      chk("redir_next_valid", {31'b0, inst_valid}, 32'd1);
      chk("redir_next_pc", inst_pc, 32'h400);
      chk("redir_next_instr", Instruction, 32'h400 ^ K);
      chk("redir_next_rom_addr", rom_addr, 32'h404);

      // 8-bit address wrap.
      fetch_en = 1'b0; fe8 = 1'b1;
      step();
      chk("wrap_count8", {29'b0, count8}, 32'd1);
      chk("wrap_pc8_fc", {24'b0, inst_pc8}, 32'hFC);
      chk("wrap_rom_addr8", {24'b0, rom_addr8}, 32'h00);
      step();
      chk("wrap_rom_addr8_b", {24'b0, rom_addr8}, 32'h04);
      fe8 = 1'b0; ready8 = 1'b1;
      step();
      chk("wrap_pc8_00", {24'b0, inst_pc8}, 32'h00);
      chk("wrap_instr8", instr8, 32'h00 ^ K);
      chk("wrap_count8_pop", {29'b0, count8}, 32'd1);
      ready8 = 1'b0;

      // Asynchronous reset pulse between edges with count=2.
      fetch_en = 1'b1;
      step();
      chk("pre_rst_count", {29'b0, count}, 32'd2);
      chk("pre_rst_rom_addr", rom_addr, 32'h408);
      #2 Reset = 1'b1;
      #1;
      chk("arst_valid", {31'b0, inst_valid}, 32'd0);
      chk("arst_rom_addr", rom_addr, 32'h0);
      chk("arst_count", {29'b0, count}, 32'd0);
      chk("arst_rom_addr8", {24'b0, rom_addr8}, 32'hFC);
      #1 Reset = 1'b0;
      @(negedge Clock);
      chk("post_rst_count", {29'b0, count}, 32'd1);
      chk("post_rst_pc", inst_pc, 32'h0);
      chk("post_rst_rom_addr", rom_addr, 32'h4);

      // Push and pop together at count=1.
      inst_ready = 1'b1;
      step();
      chk("pp1_count", {29'b0, count}, 32'd1);
      chk("pp1_pc", inst_pc, 32'h4);
      chk("pp1_rom_addr", rom_addr, 32'h8);

      // Drain to empty.
      fetch_en = 1'b0;
      step();
      chk("drain_count", {29'b0, count}, 32'd0);
      chk("drain_valid", {31'b0, inst_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 32, instruction width.
REQ-002 The block SHALL provide parameter ADDR_W, default 32, PC/ROM address width.
REQ-003 The block SHALL provide parameter DEPTH, default 4, queue entries; power of 2, >=2.
REQ-004 The block SHALL provide parameter RESET_PC, default 0, first fetch address.
REQ-005 The block SHALL provide parameter PC_STEP, default 4, PC increment per fetched word.
REQ-006 The block SHALL have port Clock, input, 1 bit, single clock; all state updates on rising edge.
REQ-007 The block SHALL have port Reset, input, 1 bit, asynchronous active-high reset.
REQ-008 The block SHALL have port fetch_en, input, 1 bit, allows new fetches when high.
REQ-009 The block SHALL have port redirect, input, 1 bit, flush and restart fetch at redirect_pc.
REQ-010 The block SHALL have port redirect_pc, input, ADDR_W bits, new fetch address.
REQ-011 The block SHALL have port rom_addr, output, ADDR_W bits, current fetch PC to combinational instruction ROM.
REQ-012 The block SHALL have port rom_data, input, DATA_W bits, ROM word at rom_addr, same cycle.
REQ-013 The block SHALL have port Instruction, output, DATA_W bits, head-of-queue instruction.
REQ-014 The block SHALL have port inst_pc, output, ADDR_W bits, address of Instruction.
REQ-015 The block SHALL have port inst_valid, output, 1 bit, queue non-empty.
REQ-016 The block SHALL have port inst_ready, input, 1 bit, consumer accepts head.
REQ-017 The block SHALL have port count, output, $clog2(DEPTH)+1 bits, occupied entries.

Function
REQ-018 rom_addr SHALL equal the internal fetch_pc register at all times.
REQ-019 push SHALL be true when fetch_en=1, redirect=0, and (count<DEPTH or pop); push stores {fetch_pc, rom_data} at tail and sets fetch_pc <= fetch_pc+PC_STEP, mod 2^ADDR_W.
REQ-020 pop SHALL be true when inst_valid=1 and inst_ready=1; head advances next edge.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, including at count=DEPTH and count=1.
REQ-022 redirect=1 SHALL take priority: next edge count<=0, head/tail pointers reset, fetch_pc<=redirect_pc, no push, any pop discarded.
REQ-023 Instruction/inst_pc SHALL be driven from registered storage at head; contents undefined when inst_valid=0.
REQ-024 inst_valid SHALL equal (count!=0); latency from push edge to inst_valid=1 is one cycle.
REQ-025 Pointers SHALL wrap modulo DEPTH; order SHALL be strict FIFO.
REQ-026 fetch_en=0 SHALL freeze fetch_pc and block push while pop continues.

Reset
REQ-027 Reset=1 SHALL immediately clear count, pointers, inst_valid=0, fetch_pc=RESET_PC (so rom_addr=RESET_PC), regardless of clock.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries; storage array need not be cleared.
REQ-029 After Reset deassertion, first push SHALL occur on the first rising edge with fetch_en=1.

Configuration
REQ-030 With macro FETCH_STAT_EN defined, block SHALL add output stat_empty, 32 bits, counting edges where Reset=0 and inst_valid=0, saturating at 32'hFFFF_FFFF, cleared only by Reset.
REQ-031 Without FETCH_STAT_EN, port stat_empty and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset release, fetch_en=1, inst_ready=0, ROM word=addr: after 4 edges count=4, rom_addr=0x10, queue holds PCs 0,4,8,C; 5th edge no change.
REQ-033 Full queue, inst_ready=1 steady: one pop and one push per edge, count stays 4, inst_pc sequence 0,4,8,C,10 consecutive.
REQ-034 count=3, redirect=1 redirect_pc=0x400 with inst_ready=1: next edge count=0, inst_valid=0, rom_addr=0x400; following edge inst_pc=0x400, inst_valid=1.
REQ-035 ADDR_W=8, fetch_pc=0xFC: push wraps fetch_pc to 0x00; inst_pc order 0xFC then 0x00.
REQ-036 Reset pulsed between clock edges while count=2: inst_valid=0 and rom_addr=RESET_PC before next edge.
REQ-037 FETCH_STAT_EN defined, fetch_en=0 for 10 edges after reset: stat_empty=10; undefined build compiles without stat_empty port.
